// File: rtl/mem_access_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_access_if
// Description : Data-memory bus between the MEM stage and the memory system.
//               One request per instruction; mem_ack completes the request
//               in the cycle it is seen together with mem_req.
// Signals     : mem_req   request valid (held until acked)
//               mem_we    1 = store, 0 = load
//               mem_addr  word-aligned byte address
//               mem_be    byte-lane enables, little-endian
//               mem_wdata store data, replicated across the active lanes
//               mem_rdata load data (full word)
//               mem_ack   request accepted / data valid this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mem_access
// Description : MEM pipeline stage. Issues byte/half/word loads and stores
//               to data memory, stalls the front of the pipeline until the
//               access is acknowledged, flags misaligned accesses and bus
//               time-outs, and registers the results for write-back.
// Parameters  : TIMEOUT  stalled cycles allowed before a bus error (2..255)
// Ports       : CLK, RST                 clock, async active-high reset
//               PC_in..Jal_data_in       EX/MEM data (ALUout_in = address,
//                                        B_in = store data)
//               WR_in, M_in, WB_in,
//               HALT_in                  EX/MEM control (M_in[3]=read,
//                                        M_in[2]=write)
//               mem                      data-memory bus (master side)
//               stall                    freezes PC .. EX/MEM while high
//               PC_out..bus_err          MEM/WB register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    input  wire logic [31:0] PC_in,
    input  wire logic [31:0] IR_in,
    input  wire logic [31:0] B_in,
    input  wire logic [31:0] ALUout_in,
    input  wire logic [31:0] Jal_data_in,
    input  wire logic [4:0]  WR_in,
    input  wire logic [3:0]  M_in,
    input  wire logic [1:0]  WB_in,
    input  wire logic        HALT_in,
    mem_access_if.master     mem,
    output logic             stall,
    output logic [31:0]      PC_out,
    output logic [31:0]      IR_out,
    output logic [31:0]      ALUout_out,
    output logic [31:0]      MDR_out,
    output logic [31:0]      Jal_data_out,
    output logic [4:0]       WR_out,
    output logic [1:0]       WB_out,
    output logic             HALT_out,
    output logic             addr_err,
    output logic             bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    // Last counter value at which a missing ack is still tolerated.
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;

    logic        w_is_byte;
    logic        w_is_half;
    logic        w_zext;
    logic        w_memop;
    logic        w_misaligned;
    logic        w_req;
    logic        w_ack;
    logic        w_stall;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte_lane;
    logic [15:0] w_half_lane;
    logic [31:0] w_load_data;
    logic        w_unused;

    // Size/sign come from the opcode: [27:26] 00=byte 01=half else word,
    // [28]=1 selects zero extension (lbu/lhu).
    assign w_is_byte = (IR_in[27:26] == 2'b00);
    assign w_is_half = (IR_in[27:26] == 2'b01);
    assign w_zext    = IR_in[28];

    assign w_memop      = M_in[3] | M_in[2];
    assign w_misaligned = (w_is_half & ALUout_in[0]) |
                          (~w_is_byte & ~w_is_half & (ALUout_in[1:0] != 2'b00));

    // Misaligned accesses never reach memory; ERR drops the request so the
    // frozen instruction can leave the stage with its bus error.
    assign w_req   = w_memop & ~w_misaligned & ~RST & (r_state != S_ERR);
    assign w_ack   = w_req & mem.mem_ack;
    assign w_stall = w_req & ~mem.mem_ack;
    assign stall   = w_stall;

    assign mem.mem_req   = w_req;
    assign mem.mem_we    = M_in[2];
    assign mem.mem_addr  = {ALUout_in[31:2], 2'b00};
    assign mem.mem_be    = w_be;
    assign mem.mem_wdata = w_wdata;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = B_in;
        if (w_is_byte) begin
            w_be    = 4'b0001 << ALUout_in[1:0];
            w_wdata = {4{B_in[7:0]}};
        end else if (w_is_half) begin
            w_be    = ALUout_in[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{B_in[15:0]}};
        end
    end

    // Lane extraction for loads (little-endian).
    always_comb begin
        w_byte_lane = mem.mem_rdata[7:0];
        case (ALUout_in[1:0])
            2'b00:   w_byte_lane = mem.mem_rdata[7:0];
            2'b01:   w_byte_lane = mem.mem_rdata[15:8];
            2'b10:   w_byte_lane = mem.mem_rdata[23:16];
            default: w_byte_lane = mem.mem_rdata[31:24];
        endcase
        w_half_lane = ALUout_in[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

        w_load_data = mem.mem_rdata;
        if (w_is_byte) begin
            w_load_data = w_zext ? {24'd0, w_byte_lane}
                                 : {{24{w_byte_lane[7]}}, w_byte_lane};
        end else if (w_is_half) begin
            w_load_data = w_zext ? {16'd0, w_half_lane}
                                 : {{16{w_half_lane[15]}}, w_half_lane};
        end
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_stall) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_req || mem.mem_ack) begin
                    w_state_next = S_IDLE;
                end else if (r_wait_cnt == C_TMO_LAST) begin
                    w_state_next = S_ERR;
                end
            end
            S_ERR: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Counts every stalled cycle of the current access, including the first
    // one seen in IDLE, so TIMEOUT stall cycles elapse before ERR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait_cnt <= 8'd0;
        end else if (w_stall) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    // The bus error is reported on the edge that leaves ERR: that is the
    // first unstalled edge for the timed-out instruction, so it retires
    // exactly once with the error attached.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PC_out       <= '0;
            IR_out       <= '0;
            ALUout_out   <= '0;
            MDR_out      <= '0;
            Jal_data_out <= '0;
            WR_out       <= '0;
            WB_out       <= '0;
            HALT_out     <= 1'b0;
            addr_err     <= 1'b0;
            bus_err      <= 1'b0;
        end else if (w_stall) begin
            PC_out       <= '0;
            IR_out       <= '0;
            ALUout_out   <= '0;
            MDR_out      <= '0;
            Jal_data_out <= '0;
            WR_out       <= '0;
            WB_out       <= '0;
            HALT_out     <= 1'b0;
            addr_err     <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            PC_out       <= PC_in;
            IR_out       <= IR_in;
            ALUout_out   <= ALUout_in;
            Jal_data_out <= Jal_data_in;
            WR_out       <= WR_in;
            MDR_out      <= '0;
            WB_out       <= '0;
            HALT_out     <= 1'b1;
            addr_err     <= 1'b0;
            bus_err      <= 1'b0;
            if (r_state == S_ERR) begin
                bus_err <= 1'b1;
            end else if (w_memop && w_misaligned) begin
                addr_err <= 1'b1;
            end else begin
                WB_out   <= WB_in;
                HALT_out <= HALT_in;
                MDR_out  <= (M_in[3] && w_ack) ? w_load_data : 32'd0;
            end
        end
    end

    // Opcode/control bits that do not affect this stage.
    assign w_unused = ^{IR_in[31:29], IR_in[25:0], M_in[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access. A transaction-level model
//               predicts bus and MEM/WB outputs every cycle; directed cases
//               pin the model with literal expectations, then random
//               instructions with random memory latency follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PC_in, IR_in, B_in, ALUout_in, Jal_data_in;
    logic [4:0]  WR_in;
    logic [3:0]  M_in;
    logic [1:0]  WB_in;
    logic        HALT_in;
    logic        stall;
    logic [31:0] PC_out, IR_out, ALUout_out, MDR_out, Jal_data_out;
    logic [4:0]  WR_out;
    logic [1:0]  WB_out;
    logic        HALT_out, addr_err, bus_err;

    mem_access_if u_bus();

    mem_access #(.TIMEOUT(TIMEOUT)) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .PC_in        (PC_in),
        .IR_in        (IR_in),
        .B_in         (B_in),
        .ALUout_in    (ALUout_in),
        .Jal_data_in  (Jal_data_in),
        .WR_in        (WR_in),
        .M_in         (M_in),
        .WB_in        (WB_in),
        .HALT_in      (HALT_in),
        .mem          (u_bus),
        .stall        (stall),
        .PC_out       (PC_out),
        .IR_out       (IR_out),
        .ALUout_out   (ALUout_out),
        .MDR_out      (MDR_out),
        .Jal_data_out (Jal_data_out),
        .WR_out       (WR_out),
        .WB_out       (WB_out),
        .HALT_out     (HALT_out),
        .addr_err     (addr_err),
        .bus_err      (bus_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] pc, ir, alu, mdr, jal;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic        halt, aerr, berr;
    } wb_t;

    wb_t exp_cur = '0;
    int  m_stalled = 0;      // stalled cycles of the instruction in MEM
    bit  m_err = 1'b0;       // time-out seen; instruction retires with error
    bit  m_stall_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (access-size arithmetic) -------------
    function automatic int unsigned m_bytes(input logic [31:0] ir);
        if (ir[27:26] == 2'b00) return 1;
        if (ir[27:26] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_misal(input logic [31:0] ir, input logic [31:0] addr);
        return (addr % m_bytes(ir)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] ir, input logic [31:0] addr);
        logic [31:0] v;
        v = ((32'd1 << m_bytes(ir)) - 32'd1) << (addr % 32'd4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] ir, input logic [31:0] b);
        logic [31:0] r;
        int n;
        n = int'(m_bytes(ir));
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] ir, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [31:0] mask, v;
        int n;
        n    = int'(m_bytes(ir));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
        v    = (rd >> (8*(addr % 32'd4))) & mask;
        if (!ir[28] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One clock: compare at negedge, predict the next edge, return at posedge+1.
    task automatic step();
        wb_t  nxt;
        logic memop, mis, req, ack;
        @(negedge CLK);
        if (RST) exp_cur = '0;
        chk("PC_out",       PC_out,            exp_cur.pc);
        chk("IR_out",       IR_out,            exp_cur.ir);
        chk("ALUout_out",   ALUout_out,        exp_cur.alu);
        chk("MDR_out",      MDR_out,           exp_cur.mdr);
        chk("Jal_data_out", Jal_data_out,      exp_cur.jal);
        chk("WR_out",       32'(WR_out),       32'(exp_cur.wr));
        chk("WB_out",       32'(WB_out),       32'(exp_cur.wb));
        chk("HALT_out",     32'(HALT_out),     32'(exp_cur.halt));
        chk("addr_err",     32'(addr_err),     32'(exp_cur.aerr));
        chk("bus_err",      32'(bus_err),      32'(exp_cur.berr));

        memop = M_in[3] | M_in[2];
        mis   = m_misal(IR_in, ALUout_in);
        ack   = u_bus.mem_ack;
        req   = memop && !mis && !RST && !m_err;
        chk("mem_req",  32'(u_bus.mem_req), 32'(req));
        chk("stall",    32'(stall),         32'(req && !ack));
        chk("mem_addr", u_bus.mem_addr,     ALUout_in & 32'hFFFF_FFFC);
        chk("mem_we",   32'(u_bus.mem_we),  32'(M_in[2]));
        if (req) begin
            chk("mem_be",    32'(u_bus.mem_be), 32'(m_be(IR_in, ALUout_in)));
            chk("mem_wdata", u_bus.mem_wdata,   m_wdata(IR_in, B_in));
        end

        nxt = '0;
        if (RST) begin
            m_stalled = 0;
            m_err     = 1'b0;
        end else if (req && !ack) begin
            m_stalled++;
            if (m_stalled == TIMEOUT) begin
                m_err     = 1'b1;
                m_stalled = 0;
            end
        end else begin
            nxt.pc  = PC_in;
            nxt.ir  = IR_in;
            nxt.alu = ALUout_in;
            nxt.jal = Jal_data_in;
            nxt.wr  = WR_in;
            if (m_err) begin
                nxt.halt = 1'b1;
                nxt.berr = 1'b1;
                m_err    = 1'b0;
            end else if (memop && mis) begin
                nxt.halt = 1'b1;
                nxt.aerr = 1'b1;
            end else begin
                nxt.wb   = WB_in;
                nxt.halt = HALT_in;
                if (M_in[3] && req) nxt.mdr = m_load(IR_in, ALUout_in, u_bus.mem_rdata);
            end
            m_stalled = 0;
        end
        m_stall_prev = req && !ack;
        @(posedge CLK);
        exp_cur = nxt;
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] b, input logic [3:0] m);
        PC_in       = $urandom;
        IR_in       = ir;
        B_in        = b;
        ALUout_in   = alu;
        Jal_data_in = $urandom;
        WR_in       = 5'($urandom);
        WB_in       = 2'($urandom);
        HALT_in     = 1'($urandom_range(0, 1));
        M_in        = m;
    endtask

    // Run until the model sees the instruction leave the stage.
    // lat < 0: random ack (instruction makes no request).
    task automatic complete(input int lat, input logic [31:0] rd, input bit rd_rand,
                            output int nstall);
        int k;
        k = 0;
        nstall = 0;
        forever begin
            if (lat < 0)          u_bus.mem_ack = 1'($urandom_range(0, 1));
            else if (lat == NEVER) u_bus.mem_ack = 1'b0;
            else                  u_bus.mem_ack = (k >= lat);
            u_bus.mem_rdata = rd_rand ? $urandom : rd;
            step();
            if (!m_stall_prev) break;
            nstall++;
            k++;
            if (k > 4*TIMEOUT) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stall_bound: got %0d stall cycles expected at most %0d", k, TIMEOUT);
                break;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ns;
        int sel, lat;
        logic [31:0] ir, alu;
        logic [3:0] m;
        logic [1:0] sz;

        // Reset with a load presented: no request may escape.
        RST = 1'b1;
        drive(32'h8C00_0000, 32'h100, 32'h0, 4'b1000);
        u_bus.mem_ack = 1'b0;
        u_bus.mem_rdata = 32'h0;
        #1;
        chk("rst mem_req", 32'(u_bus.mem_req), 32'd0);
        chk("rst stall",   32'(stall),         32'd0);
        step();
        step();
        chk("rst PC_out",  PC_out, 32'd0);
        RST = 1'b0;

        // lw, ack same cycle.
        drive(32'h8C00_0000, 32'h100, $urandom, 4'b1000);
        WB_in = 2'b10;
        complete(0, 32'hDEADBEEF, 1'b0, ns);
        chk("lw stalls", 32'(ns), 32'd0);
        chk("lw MDR",    MDR_out, 32'hDEADBEEF);
        chk("lw WB",     32'(WB_out), 32'd2);

        // Async reset clears a live MEM/WB register immediately.
        RST = 1'b1;
        #1;
        chk("async rst MDR", MDR_out, 32'd0);
        chk("async rst WB",  32'(WB_out), 32'd0);
        step();
        RST = 1'b0;

        // lb / lbu at 0x103, ack after 3 stall cycles.
        drive(32'h8000_0000, 32'h103, $urandom, 4'b1000);
        complete(3, 32'h8012_3456, 1'b0, ns);
        chk("lb stalls", 32'(ns), 32'd3);
        chk("lb MDR",    MDR_out, 32'hFFFF_FF80);
        drive(32'h9000_0000, 32'h103, $urandom, 4'b1000);
        complete(3, 32'h8012_3456, 1'b0, ns);
        chk("lbu stalls", 32'(ns), 32'd3);
        chk("lbu MDR",    MDR_out, 32'h0000_0080);

        // sh at 0x102.
        drive(32'hA400_0000, 32'h102, 32'h1234_ABCD, 4'b0100);
        u_bus.mem_ack = 1'b0;
        #1;
        chk("sh be",    32'(u_bus.mem_be),  32'hC);
        chk("sh wdata", u_bus.mem_wdata,    32'hABCD_ABCD);
        chk("sh we",    32'(u_bus.mem_we),  32'd1);
        chk("sh req",   32'(u_bus.mem_req), 32'd1);
        complete(1, 32'h0, 1'b1, ns);

        // Misaligned lw.
        drive(32'h8C00_0000, 32'h101, $urandom, 4'b1000);
        WB_in = 2'b11;
        u_bus.mem_ack = 1'b1;
        #1;
        chk("mis req",   32'(u_bus.mem_req), 32'd0);
        complete(-1, 32'h0, 1'b1, ns);
        chk("mis aerr",  32'(addr_err), 32'd1);
        chk("mis HALT",  32'(HALT_out), 32'd1);
        chk("mis WB",    32'(WB_out),   32'd0);

        // sw never acked -> bus error.
        drive(32'hAC00_0000, 32'h200, $urandom, 4'b0100);
        WB_in = 2'b11;
        complete(NEVER, 32'h0, 1'b1, ns);
        chk("tmo stalls", 32'(ns), 32'd16);
        chk("tmo berr",   32'(bus_err),  32'd1);
        chk("tmo HALT",   32'(HALT_out), 32'd1);
        chk("tmo WB",     32'(WB_out),   32'd0);
        chk("tmo MDR",    MDR_out,       32'd0);

        // Reset in the middle of a long wait, then re-present the lw.
        drive(32'h8C00_0000, 32'h300, $urandom, 4'b1000);
        u_bus.mem_ack = 1'b0;
        repeat (12) step();
        RST = 1'b1;
        #1;
        chk("wrst req",   32'(u_bus.mem_req), 32'd0);
        chk("wrst stall", 32'(stall),         32'd0);
        step();
        RST = 1'b0;
        complete(4, 32'hCAFE_F00D, 1'b0, ns);
        chk("wrst stalls", 32'(ns), 32'd4);
        chk("wrst MDR",    MDR_out, 32'hCAFE_F00D);
        chk("wrst berr",   32'(bus_err), 32'd0);

        // Random traffic.
        repeat (400) begin
            sel = int'($urandom_range(0, 3));
            m   = (sel == 0) ? 4'b0000 : ((sel == 2) ? 4'b0100 : 4'b1000);
            m[1:0] = 2'($urandom);
            case ($urandom_range(0, 2))
                0:       sz = 2'b00;
                1:       sz = 2'b01;
                default: sz = 2'b11;
            endcase
            ir = $urandom;
            ir[27:26] = sz;
            alu = $urandom;
            if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
            lat = int'($urandom_range(0, 19));
            lat = (lat == 0) ? NEVER : (lat % 5);
            if (m[3:2] == 2'b00 || m_misal(ir, alu)) lat = -1;
            drive(ir, alu, $urandom, m);
            complete(lat, 32'h0, 1'b1, ns);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
